pipe_issuer: RTL and testbench
==============================

// Module: pipe_issuer
// PURPOSE
//  Issue unit driving the MAC pipeline's one-hot inst[7:0] port. Takes instruction words from a
//  host/sequencer through a valid/ready FIFO and issues at most one per clk. Inserts NOP bubbles
//  on memory-port, load-to-MAC and MAC-to-WRITE hazards. Drops illegal words.
// PARAMETERS
//  DEPTH    4  instruction FIFO entries, power of 2, >=2
//  LD_LAT   2  memory-port cycles used by LD_DATA / LD_COEFF, >=1
//  WR_LAT   1  memory-port cycles used by WRITE, >=1
//  MAC_LAT  3  cycles until an ADD|MULT result can be written, >=1
// PORTS
//  clk        in   1  single clock, all state on posedge
//  resetn     in   1  reset, synchronous, active-low
//  in_valid   in   1  host word valid
//  in_ready   out  1  FIFO not full; push on in_valid&&in_ready
//  in_inst    in   8  one-hot instruction word (pipe_defs bit indices)
//  hold       in   1  1 = issue NOP, do not pop; hazard counters keep counting
//  inst       out  8  registered instruction to pipeline
//  busy       out  1  FIFO non-empty or any hazard counter nonzero
//  err        out  1  sticky: an illegal word was dropped
//  stall_cnt  out 16  saturating count of hazard-blocked cycles
// BEHAVIOUR
//  - Reset (resetn=0 at edge, any time incl. mid-burst): FIFO flushed, counters 0,
//    inst=1<<NOP, err=0, stall_cnt=0, in_ready=1 from first cycle after reset.
//  - Legal words: 1<<NOP, 1<<LD_DATA, 1<<LD_COEFF, 1<<ADD|1<<MULT (MAC), 1<<WRITE. Others illegal.
//  - Each edge, FIFO head H is evaluated:
//    empty or hold -> inst<=NOP, no pop, stall_cnt unchanged.
//    H illegal -> pop, inst<=NOP, err<=1 (one cycle lost, not counted as stall).
//    H legal, no hazard -> inst<=H, pop. H=NOP is popped and issued as NOP.
//    H legal, hazard -> inst<=NOP, no pop, stall_cnt+=1 (saturates at 16'hFFFF).
//  - Counters: mem_cnt, ld_cnt, mac_cnt; each decrements by 1 per edge when nonzero.
//    On issue: LD_* loads mem_cnt=LD_LAT and ld_cnt=LD_LAT; WRITE loads mem_cnt=WR_LAT;
//    MAC loads mac_cnt=MAC_LAT. Load overrides decrement on the same edge.
//  - Hazards (evaluated on pre-edge counter values):
//    LD_*, WRITE blocked while mem_cnt>1; MAC blocked while ld_cnt>1;
//    WRITE also blocked while mac_cnt>1. NOP never blocked.
//  - Latency: word pushed at edge N is at head from N+1; earliest issue at edge N+1
//    (inst valid after N+1). Back-to-back legal, hazard-free words issue one per clk.
//  - FIFO: in_ready=!full using pre-edge occupancy; push while full is refused even if a
//    pop happens the same edge. Push+pop same edge keeps occupancy. Pointers wrap modulo DEPTH.
//  - busy combinational from state; inst, err, stall_cnt registered.
// STRUCTURE
//  - pipe_defs.vh (shared): NOP=0, LD_DATA=1, LD_COEFF=2, ADD=3, MULT=4, WRITE=5,
//    MAC mask, is_legal() function; used by pipeline, issuer and benches.
//  - Sub-module pipe_inst_fifo: sync FIFO (DEPTH x 8), same clk/resetn, full/empty flags.
//  - Issuer top: hazard counters, issue/stall decision, output register.
// TESTING (defaults; edges numbered from first issue)
//  1 Push LD_DATA,LD_COEFF,MAC x4,WRITE back-to-back -> inst: LD_DATA,NOP,LD_COEFF,NOP,
//    MAC,MAC,MAC,MAC,NOP,NOP,WRITE,then NOP; stall_cnt=4, err=0, busy falls 1 clk after WRITE.
//  2 LD_COEFF,LD_DATA,MAC -> LD_COEFF,NOP,LD_DATA,NOP,MAC; stall_cnt=2.
//  3 Push 8'h0C then WRITE -> inst NOP (drop), then WRITE next edge; err=1 until reset.
//  4 hold=1, push 5 words -> in_ready=0 after 4th accepted, 5th waits; hold=0 -> all 5 issue in order.
//  5 resetn=0 one clk during MAC burst -> next cycle inst=NOP, in_ready=1, stall_cnt=0, err=0;
//    WRITE pushed next issues without stall.
//  6 No pushes for 20 clk -> inst stays 1<<NOP, busy=0, stall_cnt unchanged.

Source files
------------

// File: rtl/pipe_issuer_pkg.sv
// Instruction encodings and decode helpers for the MAC pipeline issue path.
// Words are one-hot, except MAC, which sets both the ADD and MULT bits.
package pipe_issuer_pkg;

  localparam int NOP      = 0;
  localparam int LD_DATA  = 1;
  localparam int LD_COEFF = 2;
  localparam int ADD      = 3;
  localparam int MULT     = 4;
  localparam int WRITE    = 5;

  localparam logic [7:0] I_NOP      = 8'(1 << NOP);
  localparam logic [7:0] I_LD_DATA  = 8'(1 << LD_DATA);
  localparam logic [7:0] I_LD_COEFF = 8'(1 << LD_COEFF);
  localparam logic [7:0] I_MAC      = 8'(1 << ADD) | 8'(1 << MULT);
  localparam logic [7:0] I_WRITE    = 8'(1 << WRITE);

  typedef enum logic [2:0] {
    K_NOP,
    K_LD,
    K_MAC,
    K_WR,
    K_ILL
  } kind_e;

  function automatic kind_e decode(input logic [7:0] w);
    kind_e k;
    k = K_ILL;
    case (w)
      I_NOP:                 k = K_NOP;
      I_LD_DATA, I_LD_COEFF: k = K_LD;
      I_MAC:                 k = K_MAC;
      I_WRITE:               k = K_WR;
      default:               k = K_ILL;
    endcase
    return k;
  endfunction

  function automatic logic is_legal(input logic [7:0] w);
    return decode(w) != K_ILL;
  endfunction

endpackage

// File: rtl/pipe_issuer_fifo.sv
// Synchronous instruction FIFO; a write is readable at the head one clock later.
// A push while full is refused even if the same edge pops. Pointers wrap modulo DEPTH.
module pipe_inst_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pipe_issuer.sv
// Issues at most one FIFO-buffered instruction per clock, inserting NOP bubbles on
// memory-port, load-to-MAC and MAC-to-WRITE hazards; illegal words are dropped.
module pipe_issuer
  import pipe_issuer_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int LD_LAT  = 2,
  parameter int WR_LAT  = 1,
  parameter int MAC_LAT = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_inst,
  input  logic        hold,
  output logic [7:0]  inst,
  output logic        busy,
  output logic        err,
  output logic [15:0] stall_cnt
);

  localparam int LAT_A   = (LD_LAT > WR_LAT) ? LD_LAT : WR_LAT;
  localparam int LAT_MAX = (LAT_A > MAC_LAT) ? LAT_A : MAC_LAT;
  localparam int CW      = $clog2(LAT_MAX + 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [7:0]    head;
  logic          full;
  logic          empty;
  kind_e         kind;
  logic          evaluate;
  logic          hazard;
  logic          drop;
  logic          issue;
  logic          stall;
  logic          pop;
  logic [CW-1:0] mem_cnt, ld_cnt, mac_cnt;
  logic [CW-1:0] mem_nxt, ld_nxt, mac_nxt;

  function automatic logic [CW-1:0] dec(input logic [CW-1:0] c);
    return (c != '0) ? c - 1'b1 : c;
  endfunction

  pipe_inst_fifo #(
    .DEPTH (DEPTH),
    .W     (8)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (in_valid),
    .wdata  (in_inst),
    .pop    (pop),
    .rdata  (head),
    .full   (full),
    .empty  (empty)
  );

  assign in_ready = !full;
  assign busy     = !empty || (mem_cnt != '0) || (ld_cnt != '0) || (mac_cnt != '0);

  // A counter value of 1 means the resource frees up on this very edge, so only >1 blocks.
  always_comb begin
    kind     = decode(head);
    evaluate = !empty && !hold;
    hazard   = 1'b0;
    case (kind)
      K_LD:    hazard = (mem_cnt > ONE);
      K_WR:    hazard = (mem_cnt > ONE) || (mac_cnt > ONE);
      K_MAC:   hazard = (ld_cnt > ONE);
      default: hazard = 1'b0;
    endcase
    drop  = evaluate && (kind == K_ILL);
    issue = evaluate && (kind != K_ILL) && !hazard;
    stall = evaluate && (kind != K_ILL) && hazard;
    pop   = drop || issue;

    mem_nxt = dec(mem_cnt);
    ld_nxt  = dec(ld_cnt);
    mac_nxt = dec(mac_cnt);
    if (issue) begin
      case (kind)
        K_LD: begin
          mem_nxt = CW'(LD_LAT);
          ld_nxt  = CW'(LD_LAT);
        end
        K_WR:    mem_nxt = CW'(WR_LAT);
        K_MAC:   mac_nxt = CW'(MAC_LAT);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_cnt   <= '0;
      ld_cnt    <= '0;
      mac_cnt   <= '0;
      inst      <= I_NOP;
      err       <= 1'b0;
      stall_cnt <= '0;
    end else begin
      mem_cnt <= mem_nxt;
      ld_cnt  <= ld_nxt;
      mac_cnt <= mac_nxt;
      inst    <= issue ? head : I_NOP;
      if (drop) err <= 1'b1;
      if (stall && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_issuer.sv
// Randomised and directed bench for pipe_issuer against a queue-based reference model.
module tb_pipe_issuer;

  localparam int DEPTH = 4, LD_LAT = 2, WR_LAT = 1, MAC_LAT = 3;
  localparam logic [7:0] W_NOP = 8'h01, W_LDD = 8'h02, W_LDC = 8'h04;
  localparam logic [7:0] W_MAC = 8'h18, W_WR = 8'h20;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        hold = 1'b0;
  logic [7:0]  in_inst = 8'h00;
  logic        in_ready, busy, err;
  logic [7:0]  inst;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  pipe_issuer #(
    .DEPTH(DEPTH), .LD_LAT(LD_LAT), .WR_LAT(WR_LAT), .MAC_LAT(MAC_LAT)
  ) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .hold(hold), .inst(inst), .busy(busy), .err(err),
    .stall_cnt(stall_cnt)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: queued words plus remaining busy cycles per resource.
  logic [7:0] mq[$];
  int         m_mem = 0, m_ld = 0, m_mac = 0, m_stall = 0;
  logic [7:0] m_inst = 8'h01;
  bit         m_err = 1'b0;
  bit         chk_en = 1'b0, rec = 1'b0, last_acc = 1'b0;
  logic [7:0] tr[$];
  bit         trb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_legal(input logic [7:0] w);
    return w == W_NOP || w == W_LDD || w == W_LDC || w == W_MAC || w == W_WR;
  endfunction

  function automatic bit m_blocked(input logic [7:0] w);
    bit uses_mem = (w == W_LDD || w == W_LDC || w == W_WR);
    if (uses_mem && m_mem > 1) return 1'b1;
    if (w == W_MAC && m_ld > 1) return 1'b1;
    if (w == W_WR && m_mac > 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_busy();
    return mq.size() > 0 || m_mem > 0 || m_ld > 0 || m_mac > 0;
  endfunction

  task automatic cyc(input bit v, input logic [7:0] w, input bit h, input bit rn);
    int nm, nl, nc;
    bit acc;
    logic [7:0] hw;
    @(negedge clk);
    in_valid = v; in_inst = w; hold = h; resetn = rn; chk_en = 1'b1;
    if (!rn) begin
      mq.delete();
      m_mem = 0; m_ld = 0; m_mac = 0; m_stall = 0;
      m_inst = W_NOP; m_err = 1'b0; last_acc = 1'b0;
    end else begin
      acc = v && (mq.size() < DEPTH);
      nm = (m_mem > 0) ? m_mem - 1 : 0;
      nl = (m_ld > 0) ? m_ld - 1 : 0;
      nc = (m_mac > 0) ? m_mac - 1 : 0;
      m_inst = W_NOP;
      if (mq.size() > 0 && !h) begin
        hw = mq[0];
        if (!m_legal(hw)) begin
          void'(mq.pop_front());
          m_err = 1'b1;
        end else if (m_blocked(hw)) begin
          if (m_stall < 65535) m_stall++;
        end else begin
          m_inst = hw;
          void'(mq.pop_front());
          if (hw == W_LDD || hw == W_LDC) begin nm = LD_LAT; nl = LD_LAT; end
          if (hw == W_WR) nm = WR_LAT;
          if (hw == W_MAC) nc = MAC_LAT;
        end
      end
      m_mem = nm; m_ld = nl; m_mac = nc;
      if (acc) mq.push_back(w);
      last_acc = acc;
    end
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("inst", {24'h0, inst}, {24'h0, m_inst});
      chk("in_ready", {31'h0, in_ready}, {31'h0, (mq.size() < DEPTH)});
      chk("busy", {31'h0, busy}, {31'h0, m_busy()});
      chk("err", {31'h0, err}, {31'h0, m_err});
      chk("stall_cnt", {16'h0, stall_cnt}, m_stall);
      if (rec) begin
        tr.push_back(inst);
        trb.push_back(busy);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic push_word(input logic [7:0] w, input bit h);
    int k = 0;
    do begin
      cyc(1'b1, w, h, 1'b1);
      k++;
    end while (!last_acc && k < 50);
    if (!last_acc) begin
      n_chk++; n_fail++;
      $display("FAIL push_timeout: word %0h never accepted", w);
    end
  endtask

  task automatic wait_quiet();
    int k = 0;
    while (m_busy() && k < 100) begin
      idle(1);
      k++;
    end
    idle(2);
  endtask

  task automatic idle_until(input int n);
    int k = 0;
    while (tr.size() < n && k < 40) begin
      idle(1);
      k++;
    end
  endtask

  task automatic chk_trace(input string nm, input logic [7:0] exp[$]);
    for (int i = 0; i < exp.size(); i++)
      chk($sformatf("%s[%0d]", nm, i), (i < tr.size()) ? {24'h0, tr[i]} : 32'hxxxxxxxx,
          {24'h0, exp[i]});
  endtask

  initial begin
    logic [7:0] eq[$];
    logic [7:0] pool[16];
    pool = '{8'h01, 8'h02, 8'h04, 8'h18, 8'h18, 8'h20, 8'h20, 8'h02,
             8'h00, 8'h0C, 8'hFF, 8'h03, 8'h21, 8'h18, 8'h01, 8'h04};

    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("rst_inst", {24'h0, inst}, 32'h01);
    chk("rst_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_stall", {16'h0, stall_cnt}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    idle(2);

    // Load, load, MAC burst, write-back.
    tr.delete(); trb.delete(); rec = 1'b1;
    push_word(W_LDD, 1'b0); push_word(W_LDC, 1'b0);
    repeat (4) push_word(W_MAC, 1'b0);
    push_word(W_WR, 1'b0);
    idle_until(13);
    rec = 1'b0;
    eq = '{8'h01, 8'h02, 8'h01, 8'h04, 8'h01, 8'h18, 8'h18, 8'h18, 8'h18,
           8'h01, 8'h01, 8'h20, 8'h01};
    chk_trace("t1_inst", eq);
    chk("t1_stall", {16'h0, stall_cnt}, 32'd4);
    chk("t1_err", {31'h0, err}, 32'h0);
    chk("t1_busy_at_wr", (trb.size() > 12) ? {31'h0, trb[11]} : 32'hx, 32'h1);
    chk("t1_busy_after", (trb.size() > 12) ? {31'h0, trb[12]} : 32'hx, 32'h0);

    wait_quiet();
    tr.delete(); rec = 1'b1;
    push_word(W_LDC, 1'b0); push_word(W_LDD, 1'b0); push_word(W_MAC, 1'b0);
    idle_until(6);
    rec = 1'b0;
    eq = '{8'h01, 8'h04, 8'h01, 8'h02, 8'h01, 8'h18};
    chk_trace("t2_inst", eq);
    chk("t2_stall", {16'h0, stall_cnt}, 32'd6);

    wait_quiet();
    tr.delete(); rec = 1'b1;
    push_word(8'h0C, 1'b0); push_word(W_WR, 1'b0);
    idle_until(3);
    rec = 1'b0;
    eq = '{8'h01, 8'h01, 8'h20};
    chk_trace("t3_inst", eq);
    chk("t3_err", {31'h0, err}, 32'h1);

    // Fill under hold, fifth word waits, then drain in order.
    wait_quiet();
    push_word(W_WR, 1'b1); push_word(W_LDD, 1'b1);
    push_word(W_NOP, 1'b1); push_word(W_MAC, 1'b1);
    chk("t4_ready_full", {31'h0, in_ready}, 32'h0);
    cyc(1'b1, W_MAC, 1'b1, 1'b1);
    cyc(1'b1, W_MAC, 1'b1, 1'b1);
    chk("t4_ready_held", {31'h0, in_ready}, 32'h0);
    tr.delete(); rec = 1'b1;
    push_word(W_MAC, 1'b0);
    idle_until(5);
    rec = 1'b0;
    eq = '{8'h20, 8'h02, 8'h01, 8'h18, 8'h18};
    chk_trace("t4_inst", eq);
    chk("t4_stall", {16'h0, stall_cnt}, 32'd6);
    chk("t4_err", {31'h0, err}, 32'h1);

    // Reset in the middle of a MAC burst.
    wait_quiet();
    repeat (4) push_word(W_MAC, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t5_inst", {24'h0, inst}, 32'h01);
    chk("t5_ready", {31'h0, in_ready}, 32'h1);
    chk("t5_stall", {16'h0, stall_cnt}, 32'h0);
    chk("t5_err", {31'h0, err}, 32'h0);
    tr.delete(); rec = 1'b1;
    push_word(W_WR, 1'b0);
    idle_until(2);
    rec = 1'b0;
    eq = '{8'h01, 8'h20};
    chk_trace("t5_inst", eq);
    chk("t5_stall_after", {16'h0, stall_cnt}, 32'h0);

    idle(20);
    chk("t6_inst", {24'h0, inst}, 32'h01);
    chk("t6_busy", {31'h0, busy}, 32'h0);
    chk("t6_stall", {16'h0, stall_cnt}, 32'h0);

    for (int i = 0; i < 800; i++) begin
      cyc($urandom_range(0, 3) != 0, pool[$urandom_range(0, 15)],
          $urandom_range(0, 9) == 0, $urandom_range(0, 99) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
